// File: rtl/mbinit_repairmb_sb_tx_encoder.sv
// REPAIRMB sideband TX encoder: builds the 64-bit message-without-data packet,
// streams it as NB = 64/DW beats, then holds the bus idle for GAP_CYCLES.
module mbinit_repairmb_sb_tx_encoder #(
  parameter int DW         = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [3:0]    i_TX_SbMessage,
  input  logic [2:0]    i_msg_info,
  output logic [DW-1:0] o_sb_data,
  output logic          o_sb_valid,
  output logic          o_busy,
  output logic          o_falling_edge_busy,
  output logic          o_illegal_msg,
  output logic [1:0]    o_dbg_state
);

  localparam int NB = 64 / DW;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [63:0]   pkt_q;
  logic [3:0]    beat_cnt;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    last_code;
  logic          block;

  logic [63:0]   pkt_new;
  logic          code_ok;
  logic          code_ill;
  logic          accept;
  logic          rearm;

  // Only called for legal codes 1..6; odd codes are requests, even are responses.
  function automatic logic [63:0] build_pkt(input logic [3:0] code, input logic [2:0] info);
    logic [63:0] p;
    p        = '0;
    p[4:0]   = 5'b10010;
    p[21:14] = code[0] ? 8'hA5 : 8'hAA;
    case (code)
      4'd1, 4'd2: p[39:32] = 8'h0C;
      4'd3, 4'd4: p[39:32] = 8'h0E;
      default:    p[39:32] = 8'h0D;
    endcase
    if (code == 4'd3) p[42:40] = info;
    p[63] = ^p[62:0];
    return p;
  endfunction

  function automatic logic [DW-1:0] beat_of(input logic [63:0] p, input int k);
    logic [63:0] s;
    s = p >> (k * DW);
    return s[DW-1:0];
  endfunction

  always_comb begin
    pkt_new  = build_pkt(i_TX_SbMessage, i_msg_info);
    code_ok  = (i_TX_SbMessage >= 4'd1) && (i_TX_SbMessage <= 4'd6);
    code_ill = (i_TX_SbMessage >= 4'd7);
    accept   = (state == IDLE) && i_valid && code_ok && !block;
    // A held request stays blocked until it is dropped or replaced.
    rearm    = !i_valid || (i_TX_SbMessage != last_code);
  end

  assign o_dbg_state = state;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state               <= IDLE;
      pkt_q               <= '0;
      beat_cnt            <= '0;
      gap_cnt             <= '0;
      last_code           <= '0;
      block               <= 1'b0;
      o_sb_data           <= '0;
      o_sb_valid          <= 1'b0;
      o_busy              <= 1'b0;
      o_falling_edge_busy <= 1'b0;
      o_illegal_msg       <= 1'b0;
    end else begin
      o_falling_edge_busy <= 1'b0;
      o_illegal_msg       <= 1'b0;

      if (accept) begin
        block     <= 1'b1;
        last_code <= i_TX_SbMessage;
      end else if (rearm) begin
        block <= 1'b0;
      end

      case (state)
        IDLE: begin
          o_illegal_msg <= i_valid && code_ill;
          if (accept) begin
            pkt_q      <= pkt_new;
            beat_cnt   <= '0;
            o_sb_data  <= pkt_new[DW-1:0];
            o_sb_valid <= 1'b1;
            o_busy     <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (beat_cnt == 4'(NB - 1)) begin
            o_sb_valid <= 1'b0;
            o_sb_data  <= '0;
            gap_cnt    <= '0;
            state      <= GAP;
          end else begin
            beat_cnt  <= beat_cnt + 4'd1;
            o_sb_data <= beat_of(pkt_q, int'(beat_cnt) + 1);
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            o_busy              <= 1'b0;
            o_falling_edge_busy <= 1'b1;
            state               <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mbinit_repairmb_sb_tx_encoder.md
Name: mbinit_repairmb_sb_tx_encoder

Overview:
- Consumes the REPAIRMB message request (4-bit message code, valid level, 3-bit msg info) and builds the 64-bit UCIe sideband message-without-data packet.
- Serializes the packet onto the sideband TX parallel bus, then enforces the inter-packet gap.
- Returns the busy / falling-edge-busy handshake that the REPAIRMB initiator and partner FSMs use to advance.
- Sits between the MBINIT REPAIRMB wrapper and the sideband PHY serializer.

Parameters:
- DW, 8, sideband TX bus width per beat; legal values are 8, 16, 32, 64. Beats per packet: NB = 64/DW.
- GAP_CYCLES, 4, idle cycles after the last beat before busy drops; must be ≥1.

Ports:
- CLK  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_valid  in  1  request level (the wrapper's valid output)
- i_TX_SbMessage  in  4  message code: 0 none, 1 start_req, 2 start_resp, 3 apply_degrade_req, 4 apply_degrade_resp, 5 end_req, 6 end_resp, 7-15 illegal
- i_msg_info  in  3  lane map for apply_degrade_req; ignored for other codes
- o_sb_data  out  DW  packet beat
- o_sb_valid  out  1  beat qualifier
- o_busy  out  1  encoder owns the bus (SEND or GAP)
- o_falling_edge_busy  out  1  one-cycle pulse when o_busy falls
- o_illegal_msg  out  1  one-cycle pulse when an illegal code is presented with i_valid in IDLE

Behaviour:
- Reset (rst_n=0 at a CLK edge) applies regardless of state, including mid-packet:
  - all outputs go to 0, state goes to IDLE, counters clear, the re-arm block flag clears.
  - No partial packet resumes after reset.
- Packet fields; all unspecified bits are 0:
  - [4:0] opcode = 5'b10010
  - [21:14] MsgCode: 0xA5 for req codes (1, 3, 5), 0xAA for resp codes (2, 4, 6)
  - [39:32] MsgSubcode: 0x0C for start (1, 2), 0x0E for apply_degrade (3, 4), 0x0D for end (5, 6)
  - [55:40] MsgInfo = {13'b0, i_msg_info} for code 3, else 0
  - [63] = even parity, i.e. XOR of bits [62:0]
- The packet is latched at the accept cycle. Input changes after accept do not affect the packet in flight.
- FSM IDLE:
  - Accept when i_valid=1, the code is 1-6, and the block flag is 0. Latch the packet, set the block flag, record the last code, and go to SEND on the next edge.
  - Code 0 with i_valid=1: no action.
  - Code 7-15 with i_valid=1: pulse o_illegal_msg for 1 cycle, stay in IDLE. The pulse repeats every cycle the illegal request is held.
- FSM SEND:
  - The first beat appears in the cycle after accept (accept-to-first-beat latency is 1 cycle).
  - NB consecutive cycles with o_sb_valid=1. Beat k carries packet bits [k*DW+DW-1 : k*DW], k=0 first.
  - After beat NB-1, go to GAP.
- FSM GAP:
  - GAP_CYCLES cycles with o_sb_valid=0 and o_sb_data=0, then go to IDLE.
- o_busy:
  - Registered. 1 from the cycle of the first beat through the last GAP cycle.
  - o_falling_edge_busy = 1 in the first cycle o_busy is 0 after being 1.
- Re-arm (prevents resending a held request):
  - The block flag clears when i_valid=0, or when i_TX_SbMessage differs from the last accepted code.
  - The flag is evaluated in every state. Because a clear can happen while busy, a code change during SEND/GAP is accepted in IDLE immediately after.
  - A held, unchanged request is sent exactly once.
- Back-to-back: when a new request is pending, the earliest accept is the cycle o_falling_edge_busy is high. Minimum packet period is NB+GAP_CYCLES+1 cycles.
- i_valid deasserted during SEND/GAP: the packet completes normally. There is no abort.

Test Plan:
- Start_req, DW=8, GAP=4: drive i_valid=1 with code 1.
  - Beats 0..7 are 0x12, 0x40, 0x29, 0x00, 0x0C, 0x00, 0x00, then 0x80 if parity is 1 (else 0x00).
  - o_busy is high 12 cycles, then o_falling_edge_busy pulses once.
- Apply_degrade_req with msg_info=3'b101: MsgCode 0xA5, subcode 0x0E, beat 5 = 0x05, bit 63 = XOR of [62:0].
- Held request: i_valid=1, code 2 kept for 40 cycles → exactly one packet. Drop i_valid for 1 cycle and reassert → a second packet.
- Code change while busy: switch code 1→2 during SEND → 2 accepted on the o_falling_edge_busy cycle, with the next first beat 1 cycle later.
- Illegal code 9 with i_valid=1 for 3 cycles → three o_illegal_msg pulses, o_sb_valid stays 0, o_busy stays 0.
- Reset at beat 3: rst_n=0 for 1 cycle → next cycle all outputs 0 and state IDLE. With i_valid held, the full packet restarts from beat 0. Repeat with DW=32 (2 beats).
